vram_write_port: RTL

//  Write-side counterpart of the tile fetch path: queues CPU/loader writes into the
//  2K screen RAM and commits them only in bus slots the video fetch does not use.

---
 rtl/vram_pkg.sv | 26 ++
 rtl/vram_write_port_if.sv | 21 ++
 rtl/vram_wr_fifo.sv | 65 ++++++
 rtl/vram_write_port.sv | 132 +++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared definitions for the VRAM write port: default widths, FSM encoding, pointer sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_pkg;

  localparam int VRAM_ADDR_W = 11;  // screen RAM address VA[10:0]
  localparam int VRAM_DATA_W = 8;   // tile code

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SETUP   = 2'd1;
  localparam logic [1:0] ST_WRITE   = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = ST_IDLE,
    S_SETUP   = ST_SETUP,
    S_WRITE   = ST_WRITE,
    S_RELEASE = ST_RELEASE
  } vram_state_t;

  // One extra pointer bit separates full from empty when the indices match.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vram_write_port_if.sv
// CPU/loader write request bus into the VRAM write port (valid/ready).
// Latency: n/a (wires only).
// Backpressure: a beat transfers only on a cycle where wr_valid & wr_ready.
// Members: wr_valid, wr_addr, wr_data driven by the requester (master);
//          wr_ready driven by the write port (slave).
interface vram_write_port_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) ();

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO of packed {addr,data} write entries.
// Latency: a pushed entry is visible at head (and empty drops) the clock after the push.
// Backpressure: push ignored while full, pop ignored while empty; full_nxt lets the owner register a ready.
// Ports: clk, nRESET (sync, active-low); push/push_data in; pop in;
//        head, full, empty, full_nxt (state after this edge), multi (two or more entries) out.
module vram_wr_fifo
  import vram_pkg::*;
#(
  parameter int WIDTH = VRAM_ADDR_W + VRAM_DATA_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             nRESET,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             full_nxt,
  output logic             multi
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [PW-1:0]    wptr_nxt;
  logic [PW-1:0]    rptr_nxt;
  logic [PW-1:0]    level;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok  = push & ~full;
  assign pop_ok   = pop & ~empty;
  assign wptr_nxt = wptr + {{(PW-1){1'b0}}, push_ok};
  assign rptr_nxt = rptr + {{(PW-1){1'b0}}, pop_ok};

  // Pointers wrap modulo 2*DEPTH; differing MSBs with equal indices means full.
  assign empty    = (wptr == rptr);
  assign full     = (wptr[PW-1] != rptr[PW-1]) && (wptr[IW-1:0] == rptr[IW-1:0]);
  assign full_nxt = (wptr_nxt[PW-1] != rptr_nxt[PW-1]) &&
                    (wptr_nxt[IW-1:0] == rptr_nxt[IW-1:0]);
  assign level    = wptr - rptr;
  assign multi    = (level > PW'(1));
  assign head     = mem[rptr[IW-1:0]];

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr_nxt;
      rptr <= rptr_nxt;
    end
  end

  // Storage needs no reset: pointers alone decide which slots are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[IW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vram_write_port.sv
// Queues CPU/loader writes to the 2K screen RAM and commits them in bus slots the video fetch leaves free.
// Latency: accepted write reaches ram_we no sooner than 3 clk after the push edge (push, SETUP, WRITE).
// Backpressure: wr_ready is a registered ~full; a pop on a full FIFO re-opens wr_ready one clk later.
// Ports: clk, nRESET (sync, active-low); wr (request bus, slave side);
//        vid_addr, slot_free, vblank from the video side;
//        ram_sel (1 = video address), ram_addr, ram_we, ram_wdata to the RAM; pending = FIFO not empty.
// Build option VRAM_VBLANK_BURST_EN: during vblank, WRITE chains straight into the next SETUP
// (2 clk per write); otherwise every write passes through RELEASE and vblank is ignored.
module vram_write_port
  import vram_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              nRESET,
  vram_write_port_if.slave  wr,
  input  logic [ADDR_W-1:0] vid_addr,
  input  logic              slot_free,
  input  logic              vblank,
  output logic              ram_sel,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              pending
);

  localparam int EW = ADDR_W + DATA_W;

  vram_state_t       state;
  vram_state_t       state_nxt;
  logic              push;
  logic              pop;
  logic              ready_q;
  logic [EW-1:0]     head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_full_nxt;
  logic              fifo_multi;
  logic [ADDR_W-1:0] hold_addr;
  logic [DATA_W-1:0] hold_data;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_data;
  logic              unused_ok;

  assign wr.wr_ready = ready_q;
  assign push        = wr.wr_valid & ready_q;
  assign pending     = ~fifo_empty;

  vram_wr_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nRESET    (nRESET),
    .push      (push),
    .push_data ({wr.wr_addr, wr.wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .full_nxt  (fifo_full_nxt),
    .multi     (fifo_multi)
  );

  // Entry acceptance is gated by ready_q, so the FIFO's own full flag is not needed here.
`ifdef VRAM_VBLANK_BURST_EN
  assign unused_ok = &{1'b0, fifo_full};
`else
  assign unused_ok = &{1'b0, fifo_full, fifo_multi, vblank};
`endif

  always_ff @(posedge clk) begin
    if (!nRESET) begin
      state     <= S_IDLE;
      ready_q   <= 1'b0;
      hold_addr <= '0;
      hold_data <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= ~fifo_full_nxt;
      // Head is popped at the end of WRITE; keep a copy so RELEASE still drives that address.
      if (state == S_WRITE) begin
        hold_addr <= head[EW-1:DATA_W];
        hold_data <= head[DATA_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (pending && slot_free) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        // Slot withdrawn before the strobe: give the bus back, entry stays queued.
        state_nxt = slot_free ? S_WRITE : S_IDLE;
      end
      S_WRITE: begin
        // The strobe is already on the RAM; the write completes regardless of slot_free.
        pop       = 1'b1;
        state_nxt = S_RELEASE;
`ifdef VRAM_VBLANK_BURST_EN
        if (vblank && fifo_multi && slot_free) state_nxt = S_SETUP;
`endif
      end
      S_RELEASE: begin
        // Back-to-back queued writes chain here, giving SETUP/WRITE/RELEASE = 3 clk per write.
        state_nxt = (pending && slot_free) ? S_SETUP : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cpu_addr = head[EW-1:DATA_W];
    cpu_data = head[DATA_W-1:0];
    if (state == S_RELEASE) begin
      cpu_addr = hold_addr;
      cpu_data = hold_data;
    end
  end

  assign ram_sel   = (state == S_IDLE);
  assign ram_we    = (state == S_WRITE);
  assign ram_addr  = ram_sel ? vid_addr : cpu_addr;
  assign ram_wdata = ram_sel ? '0 : cpu_data;

endmodule
